// File: rtl/zero_detect_sched_pkg.sv
// zds_pkg: shared FSM state type and default sizing for zero_detect_sched
package zds_pkg;

    typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

    localparam int N_REQ_DEF = 4;
    localparam int DW_DEF    = 8;

endpackage

// File: rtl/zero_detect_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting at ptr; ZDS_PRIO0_EN gives requester 0 fixed top priority
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDW   = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDW-1:0]   ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IDW-1:0]   gnt_id_o
);

    // scan from the farthest slot back to ptr so the last hit is the first set bit at or after ptr
    always_comb begin
        gnt_id_o = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_i[(int'(ptr_i) + k) % N_REQ]) gnt_id_o = IDW'((int'(ptr_i) + k) % N_REQ);
        end
`ifdef ZDS_PRIO0_EN
        if (req_i[0]) gnt_id_o = '0;
`endif
        gnt_o = (|req_i) ? (N_REQ'(1) << gnt_id_o) : '0;
    end

endmodule

// File: rtl/zero_detect_sched.sv
// zero_detect_sched: round-robin sharing of one zero-detect unit among N_REQ requesters (option: ZDS_PRIO0_EN)
import zds_pkg::*;

module zero_detect_sched #(
    parameter int N_REQ = N_REQ_DEF,
    parameter int DW    = DW_DEF,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req_i,
    input  logic [N_REQ*DW-1:0] req_data_i,
    output logic [N_REQ-1:0]    req_ready_o,
    output logic [DW-1:0]       zd_a_o,
    input  logic                zd_y_i,
    output logic                rsp_valid_o,
    output logic [IDW-1:0]      rsp_id_o,
    output logic                rsp_zero_o,
    input  logic                rsp_ready_i,
    output logic                busy_o
);

    state_t         state_q, state_d;
    logic [DW-1:0]  op_q, op_d;
    logic [IDW-1:0] id_q, id_d;
    logic           zero_q, zero_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] ptr_nxt;
    logic [N_REQ-1:0] gnt;
    logic [IDW-1:0]   gnt_id;

    rr_arbiter #(.N_REQ(N_REQ), .IDW(IDW)) u_arb (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .gnt_o   (gnt),
        .gnt_id_o(gnt_id)
    );

    assign ptr_nxt     = (id_q == IDW'(N_REQ - 1)) ? '0 : id_q + 1'b1;
    assign req_ready_o = (state_q == IDLE && rst_n) ? gnt : '0;
    assign zd_a_o      = op_q;
    assign rsp_valid_o = state_q == RESP;
    assign rsp_id_o    = id_q;
    assign rsp_zero_o  = zero_q;
    assign busy_o      = state_q != IDLE;

    // next-state: accept in IDLE, sample detector in EVAL, wait for handshake in RESP
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        id_d    = id_q;
        zero_d  = zero_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: if (|req_i) begin
                op_d    = req_data_i[int'(gnt_id)*DW +: DW];
                id_d    = gnt_id;
                state_d = EVAL;
            end
            EVAL: begin
                zero_d  = zd_y_i;
                state_d = RESP;
            end
            RESP: if (rsp_ready_i) begin
                state_d = IDLE;
`ifdef ZDS_PRIO0_EN
                ptr_d   = (id_q == '0) ? ptr_q : ptr_nxt;
`else
                ptr_d   = ptr_nxt;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers; reset drops any in-flight operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            id_q    <= '0;
            zero_q  <= 1'b0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            id_q    <= id_d;
            zero_q  <= zero_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule

// File: tb/tb_zero_detect_sched.sv
// tb_zero_detect_sched: directed self-checking bench for zero_detect_sched
module tb_zero_detect_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  req_ready;
    logic [7:0]  zd_a;
    logic        zd_y;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic        rsp_zero;
    logic        rsp_ready;
    logic        busy;
    int          checks = 0;
    int          errors = 0;

    zero_detect_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (req),
        .req_data_i (data),
        .req_ready_o(req_ready),
        .zd_a_o     (zd_a),
        .zd_y_i     (zd_y),
        .rsp_valid_o(rsp_valid),
        .rsp_id_o   (rsp_id),
        .rsp_zero_o (rsp_zero),
        .rsp_ready_i(rsp_ready),
        .busy_o     (busy)
    );

    assign zd_y = zd_a == 8'h00;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // starts and ends on a falling edge in IDLE; rsp_ready must be 1
    task automatic do_op(input logic [3:0] r, input logic [31:0] d, input int id, input logic z);
        req  = r;
        data = d;
        #1 check("accept_ready", req_ready, 32'(1) << id);
        @(negedge clk);
        req = 4'b0000;
        check("eval_busy", busy, 1);
        check("eval_zd_a", zd_a, d[id*8 +: 8]);
        check("eval_ready", req_ready, 0);
        @(negedge clk);
        check("rsp_valid", rsp_valid, 1);
        check("rsp_id", rsp_id, id);
        check("rsp_zero", rsp_zero, z);
        @(negedge clk);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        req       = 4'b1111;
        data      = 32'hFFFF_FFFF;
        rsp_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_zd_a", zd_a, 0);
        check("rst_valid", rsp_valid, 0);
        check("rst_id", rsp_id, 0);
        check("rst_zero", rsp_zero, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", req_ready, 0);
        req = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(4'b0010, 32'h0000_0000, 1, 1'b1);
        do_op(4'b0010, 32'h0000_2200, 1, 1'b0);

        rsp_ready = 1'b0;
        req       = 4'b0001;
        data      = 32'h0000_0005;
        @(negedge clk);
        req = 4'b0000;
        @(negedge clk);
        check("pre_rst_valid", rsp_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", rsp_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_zd_a", zd_a, 0);
        @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_valid", rsp_valid, 0);
            check("post_rst_busy", busy, 0);
        end

        do_op(4'b1111, 32'h2200_2200, 0, 1'b1);
        do_op(4'b1111, 32'h2200_2200, 1, 1'b0);
        do_op(4'b1111, 32'h2200_2200, 2, 1'b1);
        do_op(4'b1111, 32'h2200_2200, 3, 1'b0);
        do_op(4'b1111, 32'h2200_2200, 0, 1'b1);

        rsp_ready = 1'b0;
        req       = 4'b1100;
        data      = 32'h3300_4455;
        #1 check("bp_accept", req_ready, 4'b0100);
        @(negedge clk);
        req = 4'b1111;
        @(negedge clk);
        repeat (5) begin
            check("bp_valid", rsp_valid, 1);
            check("bp_id", rsp_id, 2);
            check("bp_zero", rsp_zero, 1);
            check("bp_ready", req_ready, 0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_idle_busy", busy, 0);
        check("bp_idle_ready", req_ready, 4'b1000);

        do_op(4'b1001, 32'h1100_0000, 3, 1'b0);
        do_op(4'b1001, 32'h1100_0000, 0, 1'b1);

`ifdef ZDS_PRIO0_EN
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(4'b1110, 32'h0000_2200, 1, 1'b0);
        do_op(4'b1111, 32'h0000_2200, 0, 1'b1);
        do_op(4'b1110, 32'h0000_2200, 2, 1'b1);
        do_op(4'b1110, 32'h0000_2200, 3, 1'b1);
        do_op(4'b1110, 32'h0000_2200, 1, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
